// File: rtl/fpu_seq.sv
// fpu_seq: multicycle issue controller wrapped around a combinational
// single-precision FPU. One op is accepted over valid/ready, its select and
// operands are registered into the FPU and held for LATENCY cycles, then the
// result is captured and returned with its tag over valid/ready.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       request handshake (in_ready is combinational)
//   in_sel, in_op1..3, in_tag op select, IEEE-754 single operands, dest tag
//   flush                     drop in-flight op or unconsumed result
//   out_valid / out_ready     result handshake
//   out_res, out_tag          captured result and its tag
//   busy                      op in flight or result not yet taken
//   ops_done                  completed output handshakes (wraps)
//
// FPU op selects: 0 FADD, 1 FMADD (op1*op2 rounded, then +op3 rounded),
// 2 FMUL, 3 FSUB. Round-to-nearest-even, subnormals flushed to zero,
// overflow saturates to infinity; NaN/Inf inputs are not special-cased.

module fpu_seq #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [31:0]      in_op1,
   input  logic [31:0]      in_op2,
   input  logic [31:0]      in_op3,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy,
   output logic [31:0]      ops_done
);

   localparam logic [1:0] FPU_FADD  = 2'd0;
   localparam logic [1:0] FPU_FMADD = 2'd1;
   localparam logic [1:0] FPU_FMUL  = 2'd2;
   localparam logic [1:0] FPU_FSUB  = 2'd3;

   // cnt only ever holds LATENCY-1 down to 0
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         sel_q;
   logic [31:0]        op1_q;
   logic [31:0]        op2_q;
   logic [31:0]        op3_q;
   logic [TAG_W-1:0]   tag_q;
   logic [31:0]        fpu_res;
   logic               accept;

   // Round a normalised 24-bit significand (hidden bit at [23]) with
   // guard/sticky, then pack; handles carry-out, overflow and underflow.
   function automatic logic [31:0] fp_round(input logic s, input int e,
                                            input logic [23:0] m,
                                            input logic g, input logic st);
      logic [24:0] mr;
      int          ee;
      mr = {1'b0, m} + 25'(g && (st || m[0]));
      ee = e;
      if (mr[24]) begin
         mr = mr >> 1;
         ee = ee + 1;
      end
      if (ee >= 255) return {s, 8'hFF, 23'd0};
      if (ee <= 0)   return {s, 31'd0};
      return {s, ee[7:0], mr[22:0]};
   endfunction

   // Single-precision multiply
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      logic [47:0] p;
      logic [23:0] m;
      logic        g;
      logic        st;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (p[47]) begin
         e  = e + 1;
         m  = p[47:24];
         g  = p[23];
         st = |p[22:0];
      end else begin
         m  = p[46:23];
         g  = p[22];
         st = |p[21:0];
      end
      return fp_round(s, e, m, g, st);
   endfunction

   // Single-precision add; significands carry 3 extra bits (guard, round, sticky)
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x;
      logic [31:0] y;
      logic [26:0] ax;
      logic [26:0] ay;
      logic [26:0] lost;
      logic [27:0] s;
      int          ex;
      int          d;
      // x is the operand of larger magnitude
      if (a[30:0] < b[30:0]) begin
         x = b;
         y = a;
      end else begin
         x = a;
         y = b;
      end
      ex = int'(x[30:23]);
      d  = ex - int'(y[30:23]);
      ax = (x[30:23] != 8'd0) ? {1'b1, x[22:0], 3'b000} : 27'd0;
      ay = (y[30:23] != 8'd0) ? {1'b1, y[22:0], 3'b000} : 27'd0;
      // align the smaller operand, folding shifted-out bits into sticky
      if (d >= 27) begin
         ay = {26'd0, |ay};
      end else begin
         lost = ay & ((27'd1 << d) - 27'd1);
         ay   = (ay >> d) | {26'd0, |lost};
      end
      if (x[31] == y[31]) s = {1'b0, ax} + {1'b0, ay};
      else                s = {1'b0, ax} - {1'b0, ay};
      if (s == 28'd0) return 32'd0;
      if (s[27]) begin
         s  = {1'b0, s[27:1]} | {27'd0, s[0]};
         ex = ex + 1;
      end else begin
         for (int i = 0; i < 26; i++) begin
            if (!s[26]) begin
               s  = s << 1;
               ex = ex - 1;
            end
         end
      end
      return fp_round(x[31], ex, s[26:3], s[2], |s[1:0]);
   endfunction

   // Combinational FPU on the frozen input registers
   always_comb begin
      fpu_res = 32'd0;
      case (sel_q)
         FPU_FADD:  fpu_res = fp_add(op1_q, op2_q);
         FPU_FMADD: fpu_res = fp_add(fp_mul(op1_q, op2_q), op3_q);
         FPU_FMUL:  fpu_res = fp_mul(op1_q, op2_q);
         FPU_FSUB:  fpu_res = fp_add(op1_q, {~op2_q[31], op2_q[30:0]});
         default:   fpu_res = 32'd0;
      endcase
   end

   // Accept in IDLE, or in DONE when the result leaves in the same cycle
   assign in_ready = !rst && !flush &&
                     ((state == S_IDLE) || ((state == S_DONE) && out_ready));
   assign accept   = in_valid && in_ready;
   assign busy     = (state != S_IDLE);

   // Controller FSM and all registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         sel_q     <= 2'd0;
         op1_q     <= 32'd0;
         op2_q     <= 32'd0;
         op3_q     <= 32'd0;
         tag_q     <= '0;
         out_valid <= 1'b0;
         out_res   <= 32'd0;
         out_tag   <= '0;
         ops_done  <= 32'd0;
      end else if (flush) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else begin
         // accept only happens in IDLE or on the DONE handshake cycle
         if (accept) begin
            sel_q <= in_sel;
            op1_q <= in_op1;
            op2_q <= in_op2;
            op3_q <= in_op3;
            tag_q <= in_tag;
            cnt   <= CNT_W'(LATENCY - 1);
         end
         case (state)
            S_IDLE: begin
               if (accept) state <= S_EXEC;
            end
            S_EXEC: begin
               if (cnt == '0) begin
                  out_res   <= fpu_res;
                  out_tag   <= tag_q;
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  ops_done  <= ops_done + 32'd1;
                  out_valid <= 1'b0;
                  state     <= accept ? S_EXEC : S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fpu_seq.sv
// Bench for fpu_seq: a timestamp/real-arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed results. Two extra instances
// (LATENCY 1 and 4) share the stimulus for the latency-variant check.

module tb_fpu_seq;

   localparam int unsigned LAT   = 2;
   localparam int unsigned TAG_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [1:0]       in_sel;
   logic [31:0]      in_op1;
   logic [31:0]      in_op2;
   logic [31:0]      in_op3;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_ready;

   logic             in_ready, out_valid, busy;
   logic [31:0]      out_res, ops_done;
   logic [TAG_W-1:0] out_tag;

   logic             l1_in_ready, l1_out_valid, l1_busy;
   logic [31:0]      l1_out_res, l1_ops_done;
   logic [TAG_W-1:0] l1_out_tag;
   logic             l4_in_ready, l4_out_valid, l4_busy;
   logic [31:0]      l4_out_res, l4_ops_done;
   logic [TAG_W-1:0] l4_out_tag;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fpu_seq #(.LATENCY(LAT), .TAG_W(TAG_W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_sel(in_sel), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
      .in_tag(in_tag), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
      .busy(busy), .ops_done(ops_done));

   fpu_seq #(.LATENCY(1), .TAG_W(TAG_W)) u_lat1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l1_in_ready),
      .in_sel(in_sel), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
      .in_tag(in_tag), .flush(flush), .out_valid(l1_out_valid),
      .out_ready(out_ready), .out_res(l1_out_res), .out_tag(l1_out_tag),
      .busy(l1_busy), .ops_done(l1_ops_done));

   fpu_seq #(.LATENCY(4), .TAG_W(TAG_W)) u_lat4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(l4_in_ready),
      .in_sel(in_sel), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
      .in_tag(in_tag), .flush(flush), .out_valid(l4_out_valid),
      .out_ready(out_ready), .out_res(l4_out_res), .out_tag(l4_out_tag),
      .busy(l4_busy), .ops_done(l4_ops_done));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference arithmetic via reals ----------------
   function automatic real s2r(input logic [31:0] b);
      real r;
      if (b[30:23] == 8'd0) return 0.0;
      r = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** real'(int'(b[30:23]) - 127));
      return b[31] ? -r : r;
   endfunction

   // round a double to the nearest-even single
   function automatic logic [31:0] r2s(input real r);
      logic [63:0] d;
      logic [52:0] f;
      logic [24:0] m;
      logic        s;
      int          e;
      if (r == 0.0) return 32'd0;
      d = $realtobits(r);
      s = d[63];
      e = int'(d[62:52]) - 1023 + 127;
      f = {1'b1, d[51:0]};
      m = {1'b0, f[52:29]};
      if (f[28] && ((|f[27:0]) || m[0])) m = m + 25'd1;
      if (m[24]) begin
         m = m >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0)   return {s, 31'd0};
      return {s, 8'(e), m[22:0]};
   endfunction

   function automatic logic [31:0] model_fpu(input logic [1:0] sel, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] c);
      case (sel)
         2'd0:    return r2s(s2r(a) + s2r(b));
         2'd1:    return r2s(s2r(r2s(s2r(a) * s2r(b))) + s2r(c));
         2'd2:    return r2s(s2r(a) * s2r(b));
         default: return r2s(s2r(a) - s2r(b));
      endcase
   endfunction

   // ---------------- transaction model: one slot with a due cycle ----------------
   int               cyc    = 0;
   int               p_due  = 0;
   logic             pend   = 1'b0;
   logic             m_init = 1'b0;
   logic [31:0]      p_res  = 32'd0;
   logic [TAG_W-1:0] p_tag  = '0;
   logic [31:0]      m_res  = 32'd0;
   logic [TAG_W-1:0] m_tag  = '0;
   logic [31:0]      m_done = 32'd0;

   initial begin : model
      logic rdy;
      forever begin
         @(posedge clk);
         rdy = !rst && !flush && (!pend || (cyc >= p_due && out_ready));
         if (rst) begin
            pend   = 1'b0;
            m_res  = 32'd0;
            m_tag  = '0;
            m_done = 32'd0;
            m_init = 1'b1;
         end else if (flush) begin
            pend = 1'b0;
         end else begin
            if (pend && cyc >= p_due && out_ready) begin
               m_done = m_done + 32'd1;
               pend   = 1'b0;
            end
            if (in_valid && rdy) begin
               pend  = 1'b1;
               p_res = model_fpu(in_sel, in_op1, in_op2, in_op3);
               p_tag = in_tag;
               p_due = cyc + 1 + int'(LAT);
            end
         end
         cyc = cyc + 1;
         if (!rst && !flush && pend && cyc == p_due) begin
            m_res = p_res;
            m_tag = p_tag;
         end
      end
   end

   initial begin : compare
      logic e_rdy;
      forever begin
         @(negedge clk);
         if (m_init) begin
            e_rdy = !rst && !flush && (!pend || (cyc >= p_due && out_ready));
            chk("cyc_out_valid", 32'(out_valid), 32'(pend && cyc >= p_due));
            chk("cyc_in_ready",  32'(in_ready),  32'(e_rdy));
            chk("cyc_busy",      32'(busy),      32'(pend));
            chk("cyc_ops_done",  ops_done,       m_done);
            chk("cyc_out_res",   out_res,        m_res);
            chk("cyc_out_tag",   32'(out_tag),   32'(m_tag));
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [TAG_W-1:0] tag);
      int n = 0;
      in_sel = sel; in_op1 = a; in_op2 = b; in_op3 = c; in_tag = tag;
      in_valid = 1'b1;
      #1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      chk("accept_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // posedges from return of issue() until out_valid is seen
   task automatic wait_out(output int n);
      n = 0;
      do begin
         @(posedge clk); #2;
         n++;
      end while (!out_valid && n < 30);
      chk("out_valid_wait", 32'(out_valid), 32'd1);
   endtask

   task automatic run_vec(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [TAG_W-1:0] tag,
                          input logic [31:0] exp);
      int n;
      issue(sel, a, b, c, tag);
      wait_out(n);
      chk("vec_latency", 32'(n), 32'(LAT));
      chk("vec_res", out_res, exp);
      chk("vec_tag", 32'(out_tag), 32'(tag));
   endtask

   // ---------------- directed sequence ----------------
   initial begin : stim
      int n;
      int n1, n2, n4;
      logic [31:0] d0;
      rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_op1 = 32'd0; in_op2 = 32'd0;
      in_op3 = 32'd0; in_tag = '0; flush = 1'b0; out_ready = 1'b1;

      // model pins
      chk("pin_fadd",  model_fpu(2'd0, 32'h3F800000, 32'h3F800000, 32'd0), 32'h40000000);
      chk("pin_fmadd", model_fpu(2'd1, 32'h400CCCCD, 32'h400CCCCD, 32'hBF570A3D), 32'h40800000);
      chk("pin_fmul",  model_fpu(2'd2, 32'h3FC00000, 32'h40000000, 32'd0), 32'h40400000);

      // reset state
      @(posedge clk); #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_ops_done", ops_done, 32'd0);
      chk("rst_out_res", out_res, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // test 1 on LATENCY 2, 1 and 4 at once
      issue(2'd0, 32'h3F800000, 32'h3F800000, 32'd0, 5'd3);
      n1 = 0; n2 = 0; n4 = 0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); #2;
         if (out_valid    && n2 == 0) n2 = i;
         if (l1_out_valid && n1 == 0) n1 = i;
         if (l4_out_valid && n4 == 0) n4 = i;
      end
      chk("t1_lat2", 32'(n2), 32'd2);
      chk("t1_lat1", 32'(n1), 32'd1);
      chk("t1_lat4", 32'(n4), 32'd4);
      chk("t1_res", out_res, 32'h40000000);
      chk("t1_tag", 32'(out_tag), 32'd3);
      chk("t1_ops_done", ops_done, 32'd1);
      chk("t1_l1_res", l1_out_res, 32'h40000000);
      chk("t1_l4_res", l4_out_res, 32'h40000000);
      chk("t1_l1_tag", 32'(l1_out_tag), 32'd3);
      chk("t1_l4_tag", 32'(l4_out_tag), 32'd3);
      chk("t1_l1_done", l1_ops_done, 32'd1);
      chk("t1_l4_done", l4_ops_done, 32'd1);
      chk("t1_l1_idle", 32'({l1_busy, l1_in_ready}), 32'd1);
      chk("t1_l4_idle", 32'({l4_busy, l4_in_ready}), 32'd1);

      // tests 2 and 4: table of ops, issued back-to-back on the DONE handshake
      d0 = ops_done;
      run_vec(2'd1, 32'h400CCCCD, 32'h400CCCCD, 32'hBF570A3D, 5'd7,  32'h40800000);
      run_vec(2'd1, 32'h00000000, 32'h400CCCCD, 32'h400CCCCD, 5'd8,  32'h400CCCCD);
      run_vec(2'd2, 32'h3FC00000, 32'h40000000, 32'd0,        5'd9,  32'h40400000);
      run_vec(2'd3, 32'h40400000, 32'h3F800000, 32'd0,        5'd10, 32'h40000000);
      run_vec(2'd0, 32'h3F800000, 32'hBF800000, 32'd0,        5'd11, 32'h00000000);
      run_vec(2'd0, 32'hC0000000, 32'h3F800000, 32'd0,        5'd31, 32'hBF800000);
      @(posedge clk); #2;
      chk("t4_ops_done", ops_done, d0 + 32'd6);
      chk("t4_idle", 32'(out_valid), 32'd0);

      // test 3: backpressure
      out_ready = 1'b0;
      issue(2'd0, 32'h409AE148, 32'hBF570A3D, 32'd0, 5'd9);
      wait_out(n);
      d0 = ops_done;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         chk("t3_valid_held", 32'(out_valid), 32'd1);
         chk("t3_res_stable", out_res, 32'h40800000);
         chk("t3_in_ready", 32'(in_ready), 32'd0);
         chk("t3_busy", 32'(busy), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk); #2;
      chk("t3_taken", 32'(out_valid), 32'd0);
      chk("t3_ops_done", ops_done, d0 + 32'd1);
      chk("t3_res_kept", out_res, 32'h40800000);

      // test 5: flush in EXEC
      d0 = ops_done;
      issue(2'd0, 32'h3F800000, 32'h3F800000, 32'd0, 5'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      #1;
      chk("t5_exec_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #2;
         chk("t5_exec_no_valid", 32'(out_valid), 32'd0);
      end
      // flush in DONE, with a competing request and out_ready in the same cycle
      out_ready = 1'b0;
      issue(2'd2, 32'h3FC00000, 32'h3FC00000, 32'd0, 5'd2);
      wait_out(n);
      flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("t5_done_valid", 32'(out_valid), 32'd0);
      chk("t5_done_busy", 32'(busy), 32'd0);
      chk("t5_ops_done", ops_done, d0);
      run_vec(2'd0, 32'h00000000, 32'h400CCCCD, 32'd0, 5'd4, 32'h400CCCCD);
      @(posedge clk); #2;

      // test 6: reset mid-EXEC
      issue(2'd0, 32'h3F800000, 32'h3F800000, 32'd0, 5'd5);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_ops_done", ops_done, 32'd0);
      chk("t6_res", out_res, 32'd0);
      chk("t6_tag", 32'(out_tag), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         chk("t6_no_valid", 32'(out_valid), 32'd0);
      end
      run_vec(2'd0, 32'h3F800000, 32'h3F800000, 32'd0, 5'd3, 32'h40000000);
      @(posedge clk); #2;
      chk("t6_recover_done", ops_done, 32'd1);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
